controller_sequencer: RTL and testbench

Control unit that drives every control input of the datapath from the instruction register contents (`controller_sequencer_input`) and the ALU flags. It contains a one-hot ring counter (T-states), a fetch/extended-fetch sequencer, an opcode decoder and a halt latch. It sits beside the datapath in the CPU top level and replaces the hard-tied control constants used during datapath bring-up.

---
 rtl/controller_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_controller_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// ============================================================================
//  Module      : controller_sequencer
//  Description : CPU control unit. One-hot T-state ring counter,
//                fetch/extended-fetch sequencer, opcode decoder and halt
//                latch. Drives every datapath control from the state, the
//                opcode (instruction register bits [7:4]) and the ALU flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_sequencer (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [7:0] controller_sequencer_input,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       count_pc,
  output logic       clear_pc,
  output logic       enable_pc,
  output logic       load_pc,
  output logic       load_accum,
  output logic       enable_accum,
  output logic       load_mar,
  output logic       ce_ram,
  output logic       we_ram,
  output logic       sub_mode,
  output logic       enable_alu,
  output logic       load_mdr_reg,
  output logic       enable_mdr_reg,
  output logic       load_b_reg,
  output logic       enable_b_reg,
  output logic       load_c_reg,
  output logic       enable_c_reg,
  output logic       load_temp_reg,
  output logic       load_output_reg,
  output logic       load_inst_reg,
  output logic       enable_inst_reg,
  output logic       clear_inst_reg,
  output logic [9:0] t_state,
  output logic       extended_fetch,
  output logic       halted
);

  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_T8   = 4'd9,
    ST_T9   = 4'd10,
    ST_HALT = 4'd11
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_MVB = 4'h5;
  localparam logic [3:0] OP_MVC = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] opcode;
  logic       is_two_byte;   // instruction carries an operand/address byte
  logic       is_mem_ref;    // operand byte is a RAM address (LDA/ADD/SUB/STA)
  logic       is_jump;
  logic       jump_taken;
  logic       unused_low_nibble;

  assign opcode            = controller_sequencer_input[7:4];
  assign unused_low_nibble = ^controller_sequencer_input[3:0];

  assign is_mem_ref  = (opcode >= OP_LDA) && (opcode <= OP_STA);
  assign is_jump     = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_JC);
  assign is_two_byte = is_mem_ref || is_jump;

  // Flags are only meaningful in T5; a not-taken jump still skips the operand byte.
  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && zero_flag) ||
                      ((opcode == OP_JC) && carry_flag);

  // Next-state sequencing: fetch, optional extended fetch, execute, back to T0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (opcode == OP_HLT)  state_d = ST_HALT;
        else if (is_two_byte)  state_d = ST_T4;
        else                   state_d = ST_T0;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = is_jump ? ST_T0 : ST_T6;
      ST_T6:   state_d = ((opcode == OP_ADD) || (opcode == OP_SUB)) ? ST_T7 : ST_T0;
      ST_T7:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      // T8/T9 are unused; any corrupted encoding recovers through T0.
      default: state_d = ST_T0;
    endcase
  end

  // State register; clear_n forces INIT immediately, including from HALT.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // One-hot T-state view of the sequencer; HALT shows T3 held.
  always_comb begin
    t_state = 10'd0;
    case (state_q)
      ST_T0:   t_state = 10'b00_0000_0001;
      ST_T1:   t_state = 10'b00_0000_0010;
      ST_T2:   t_state = 10'b00_0000_0100;
      ST_T3:   t_state = 10'b00_0000_1000;
      ST_T4:   t_state = 10'b00_0001_0000;
      ST_T5:   t_state = 10'b00_0010_0000;
      ST_T6:   t_state = 10'b00_0100_0000;
      ST_T7:   t_state = 10'b00_1000_0000;
      ST_T8:   t_state = 10'b01_0000_0000;
      ST_T9:   t_state = 10'b10_0000_0000;
      ST_HALT: t_state = 10'b00_0000_1000;
      default: t_state = 10'd0;
    endcase
  end

  assign halted         = (state_q == ST_HALT);
  assign extended_fetch = is_two_byte &&
                          ((state_q == ST_T3) || (state_q == ST_T4) || (state_q == ST_T5));

  // These register paths are never used by this instruction set.
  assign load_mdr_reg    = 1'b0;
  assign enable_mdr_reg  = 1'b0;
  assign enable_b_reg    = 1'b0;
  assign enable_c_reg    = 1'b0;
  assign enable_inst_reg = 1'b0;

  // Control decode per state and opcode; anything not driven stays 0.
  always_comb begin
    count_pc        = 1'b0;
    clear_pc        = 1'b0;
    enable_pc       = 1'b0;
    load_pc         = 1'b0;
    load_accum      = 1'b0;
    enable_accum    = 1'b0;
    load_mar        = 1'b0;
    ce_ram          = 1'b0;
    we_ram          = 1'b0;
    sub_mode        = 1'b0;
    enable_alu      = 1'b0;
    load_b_reg      = 1'b0;
    load_c_reg      = 1'b0;
    load_temp_reg   = 1'b0;
    load_output_reg = 1'b0;
    load_inst_reg   = 1'b0;
    clear_inst_reg  = 1'b0;
    case (state_q)
      ST_INIT: begin
        clear_pc       = 1'b1;
        clear_inst_reg = 1'b1;
      end
      ST_T0: begin
        enable_pc = 1'b1;
        load_mar  = 1'b1;
      end
      ST_T1: count_pc = 1'b1;
      ST_T2: begin
        ce_ram        = 1'b1;
        load_inst_reg = 1'b1;
      end
      ST_T3: begin
        if (is_two_byte) begin
          enable_pc = 1'b1;
          load_mar  = 1'b1;
        end else begin
          case (opcode)
            OP_MVB: begin enable_accum = 1'b1; load_b_reg      = 1'b1; end
            OP_MVC: begin enable_accum = 1'b1; load_c_reg      = 1'b1; end
            OP_OUT: begin enable_accum = 1'b1; load_output_reg = 1'b1; end
            default: ;
          endcase
        end
      end
      ST_T4: count_pc = is_two_byte;
      ST_T5: begin
        // Operand byte goes onto the bus: into MAR for memory ops, PC for taken jumps.
        ce_ram   = is_two_byte;
        load_mar = is_mem_ref;
        load_pc  = is_jump && jump_taken;
      end
      ST_T6: begin
        case (opcode)
          OP_LDA:         begin ce_ram = 1'b1; load_accum    = 1'b1; end
          OP_ADD, OP_SUB: begin ce_ram = 1'b1; load_temp_reg = 1'b1; end
          OP_STA:         begin enable_accum = 1'b1; we_ram  = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
          enable_alu = 1'b1;
          load_accum = 1'b1;
          sub_mode   = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_controller_sequencer.sv
// ============================================================================
//  Module      : tb_controller_sequencer
//  Description : Directed self-checking bench for controller_sequencer.
//                Walks each instruction class state by state against
//                hand-written expected T-state and control vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_sequencer;

  logic       clk;
  logic       clear_n;
  logic [7:0] ir;
  logic       zero_flag;
  logic       carry_flag;
  logic       count_pc, clear_pc, enable_pc, load_pc;
  logic       load_accum, enable_accum;
  logic       load_mar, ce_ram, we_ram;
  logic       sub_mode, enable_alu;
  logic       load_mdr_reg, enable_mdr_reg, load_b_reg, enable_b_reg;
  logic       load_c_reg, enable_c_reg, load_temp_reg, load_output_reg;
  logic       load_inst_reg, enable_inst_reg, clear_inst_reg;
  logic [9:0] t_state;
  logic       extended_fetch;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Control-vector bit masks (bit order matches the concatenation below).
  localparam logic [21:0] M_COUNT_PC  = 22'h1 << 21;
  localparam logic [21:0] M_CLEAR_PC  = 22'h1 << 20;
  localparam logic [21:0] M_EN_PC     = 22'h1 << 19;
  localparam logic [21:0] M_LOAD_PC   = 22'h1 << 18;
  localparam logic [21:0] M_LOAD_ACC  = 22'h1 << 17;
  localparam logic [21:0] M_EN_ACC    = 22'h1 << 16;
  localparam logic [21:0] M_LOAD_MAR  = 22'h1 << 15;
  localparam logic [21:0] M_CE_RAM    = 22'h1 << 14;
  localparam logic [21:0] M_WE_RAM    = 22'h1 << 13;
  localparam logic [21:0] M_SUB       = 22'h1 << 12;
  localparam logic [21:0] M_EN_ALU    = 22'h1 << 11;
  localparam logic [21:0] M_LOAD_B    = 22'h1 << 8;
  localparam logic [21:0] M_LOAD_C    = 22'h1 << 6;
  localparam logic [21:0] M_LOAD_TMP  = 22'h1 << 4;
  localparam logic [21:0] M_LOAD_OUT  = 22'h1 << 3;
  localparam logic [21:0] M_LOAD_IR   = 22'h1 << 2;
  localparam logic [21:0] M_CLEAR_IR  = 22'h1 << 0;

  controller_sequencer dut (
    .clk                        (clk),
    .clear_n                    (clear_n),
    .controller_sequencer_input (ir),
    .zero_flag                  (zero_flag),
    .carry_flag                 (carry_flag),
    .count_pc                   (count_pc),
    .clear_pc                   (clear_pc),
    .enable_pc                  (enable_pc),
    .load_pc                    (load_pc),
    .load_accum                 (load_accum),
    .enable_accum               (enable_accum),
    .load_mar                   (load_mar),
    .ce_ram                     (ce_ram),
    .we_ram                     (we_ram),
    .sub_mode                   (sub_mode),
    .enable_alu                 (enable_alu),
    .load_mdr_reg               (load_mdr_reg),
    .enable_mdr_reg             (enable_mdr_reg),
    .load_b_reg                 (load_b_reg),
    .enable_b_reg               (enable_b_reg),
    .load_c_reg                 (load_c_reg),
    .enable_c_reg               (enable_c_reg),
    .load_temp_reg              (load_temp_reg),
    .load_output_reg            (load_output_reg),
    .load_inst_reg              (load_inst_reg),
    .enable_inst_reg            (enable_inst_reg),
    .clear_inst_reg             (clear_inst_reg),
    .t_state                    (t_state),
    .extended_fetch             (extended_fetch),
    .halted                     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] exp_t,
                       input logic [21:0] exp_ctrl, input logic exp_ext,
                       input logic exp_halt);
    logic [33:0] obs;
    logic [33:0] exp;
    obs = {t_state, extended_fetch, halted,
           count_pc, clear_pc, enable_pc, load_pc, load_accum, enable_accum,
           load_mar, ce_ram, we_ram, sub_mode, enable_alu,
           load_mdr_reg, enable_mdr_reg, load_b_reg, enable_b_reg,
           load_c_reg, enable_c_reg, load_temp_reg, load_output_reg,
           load_inst_reg, enable_inst_reg, clear_inst_reg};
    exp = {exp_t, exp_ext, exp_halt, exp_ctrl};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {t,ext,halt,ctrl}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Common fetch: entered sampling T0, leaves sampling T3.
  task automatic fetch(input string tag);
    check({tag, " T0"}, 10'h001, M_EN_PC | M_LOAD_MAR, 1'b0, 1'b0);
    step();
    check({tag, " T1"}, 10'h002, M_COUNT_PC, 1'b0, 1'b0);
    step();
    check({tag, " T2"}, 10'h004, M_CE_RAM | M_LOAD_IR, 1'b0, 1'b0);
    step();
  endtask

  // Operand fetch T3..T5 of two-byte instructions; t5_ctrl differs per opcode.
  task automatic ext_fetch(input string tag, input logic [21:0] t5_ctrl);
    check({tag, " T3"}, 10'h008, M_EN_PC | M_LOAD_MAR, 1'b1, 1'b0);
    step();
    check({tag, " T4"}, 10'h010, M_COUNT_PC, 1'b1, 1'b0);
    step();
    check({tag, " T5"}, 10'h020, t5_ctrl, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    clear_n    = 1'b0;
    ir         = 8'h00;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
    #20;
    check("reset INIT", 10'h000, M_CLEAR_PC | M_CLEAR_IR, 1'b0, 1'b0);
    clear_n = 1'b1;
    step();

    // ADD: 8 cycles, sub_mode low in T7
    ir = 8'h2F;
    fetch("ADD");
    ext_fetch("ADD", M_CE_RAM | M_LOAD_MAR);
    check("ADD T6", 10'h040, M_CE_RAM | M_LOAD_TMP, 1'b0, 1'b0);
    step();
    check("ADD T7", 10'h080, M_EN_ALU | M_LOAD_ACC, 1'b0, 1'b0);
    step();

    // SUB: same shape, sub_mode high in T7
    ir = 8'h3F;
    fetch("SUB");
    ext_fetch("SUB", M_CE_RAM | M_LOAD_MAR);
    check("SUB T6", 10'h040, M_CE_RAM | M_LOAD_TMP, 1'b0, 1'b0);
    step();
    check("SUB T7", 10'h080, M_EN_ALU | M_LOAD_ACC | M_SUB, 1'b0, 1'b0);
    step();

    // JZ taken / not taken (carry set on the not-taken pass must not matter)
    ir = 8'h80; zero_flag = 1'b1;
    fetch("JZ taken");
    ext_fetch("JZ taken", M_CE_RAM | M_LOAD_PC);
    ir = 8'h80; zero_flag = 1'b0; carry_flag = 1'b1;
    fetch("JZ not");
    ext_fetch("JZ not", M_CE_RAM);

    // JC taken / not taken (zero set on the not-taken pass must not matter)
    ir = 8'h90; zero_flag = 1'b0; carry_flag = 1'b1;
    fetch("JC taken");
    ext_fetch("JC taken", M_CE_RAM | M_LOAD_PC);
    ir = 8'h90; zero_flag = 1'b1; carry_flag = 1'b0;
    fetch("JC not");
    ext_fetch("JC not", M_CE_RAM);

    // JMP is unconditional
    ir = 8'h70; zero_flag = 1'b0; carry_flag = 1'b0;
    fetch("JMP");
    ext_fetch("JMP", M_CE_RAM | M_LOAD_PC);

    // Single-byte instructions: 4 cycles
    ir = 8'h50;
    fetch("MOVB");
    check("MOVB T3", 10'h008, M_EN_ACC | M_LOAD_B, 1'b0, 1'b0);
    step();
    ir = 8'h60;
    fetch("MOVC");
    check("MOVC T3", 10'h008, M_EN_ACC | M_LOAD_C, 1'b0, 1'b0);
    step();
    ir = 8'hE0;
    fetch("OUT");
    check("OUT T3", 10'h008, M_EN_ACC | M_LOAD_OUT, 1'b0, 1'b0);
    step();
    ir = 8'hA5;
    fetch("NOP-A");
    check("NOP-A T3", 10'h008, 22'h0, 1'b0, 1'b0);
    step();

    // LDA / STA: 7 cycles
    ir = 8'h10;
    fetch("LDA");
    ext_fetch("LDA", M_CE_RAM | M_LOAD_MAR);
    check("LDA T6", 10'h040, M_CE_RAM | M_LOAD_ACC, 1'b0, 1'b0);
    step();
    ir = 8'h40;
    fetch("STA");
    ext_fetch("STA", M_CE_RAM | M_LOAD_MAR);
    check("STA T6", 10'h040, M_EN_ACC | M_WE_RAM, 1'b0, 1'b0);
    step();

    // Asynchronous reset in the middle of ADD at T6
    ir = 8'h2F;
    fetch("ADDrst");
    ext_fetch("ADDrst", M_CE_RAM | M_LOAD_MAR);
    check("ADDrst T6", 10'h040, M_CE_RAM | M_LOAD_TMP, 1'b0, 1'b0);
    #2 clear_n = 1'b0;
    #1 check("async reset INIT", 10'h000, M_CLEAR_PC | M_CLEAR_IR, 1'b0, 1'b0);
    clear_n = 1'b1;
    step();
    check("restart T0", 10'h001, M_EN_PC | M_LOAD_MAR, 1'b0, 1'b0);

    // HLT: T3 empty, then HALT held with T3 shown
    ir = 8'hF0;
    fetch("HLT");
    check("HLT T3", 10'h008, 22'h0, 1'b0, 1'b0);
    step();
    ir = 8'h2F;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("HALT hold %0d", i), 10'h008, 22'h0, 1'b0, 1'b1);
      step();
    end
    #2 clear_n = 1'b0;
    #1 check("HALT reset INIT", 10'h000, M_CLEAR_PC | M_CLEAR_IR, 1'b0, 1'b0);
    clear_n = 1'b1;
    step();
    check("post-halt T0", 10'h001, M_EN_PC | M_LOAD_MAR, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
